// File: rtl/reg_file_sb.sv
// reg_file_sb: two-read, one-write register file with a per-register busy
// scoreboard. Reads are combinational with same-cycle writeback bypass.
// Issued destinations are marked busy until their writeback returns.
// A sticky error flag records an issue to a register that is still busy.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic [ADDR_W:0]   busy_cnt,
    output logic              err
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;

    logic wr_live;
    logic iss_live;
    logic wr_ok;
    logic iss_ok;
    logic same_dst;
    logic clr_ok;
    logic cnt_inc;
    logic cnt_dec;
    logic dbl_iss;

    // True when addr names the hardwired-zero register.
    function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Read data for one port: hardwired zero first, then bypass, then storage.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr,
                                                     input logic            live,
                                                     input logic [DATA_W-1:0] stored);
        if (is_zero(addr))
            return '0;
        else if (live && (wr_addr == addr))
            return wr_data;
        else
            return stored;
    endfunction

    // Strobes are gated by reset so the bypass path is also quiet in reset.
    always_comb begin
        wr_live  = wr_en & rst_n;
        iss_live = iss_en & rst_n;
        wr_ok    = wr_live && !is_zero(wr_addr);
        iss_ok   = iss_live && !is_zero(iss_addr);
        same_dst = wr_ok && iss_ok && (wr_addr == iss_addr);
        // A writeback to a busy register frees it unless a new producer claims it.
        clr_ok   = wr_ok && busy[wr_addr] && !same_dst;
        cnt_inc  = iss_ok && !busy[iss_addr];
        cnt_dec  = clr_ok;
        // Re-issue to a busy register is only legal when its writeback lands now.
        dbl_iss  = iss_ok && busy[iss_addr] && !same_dst;
    end

    // Combinational read ports with writeback bypass and busy hiding.
    always_comb begin
        rd_data_a = read_port(rd_addr_a, wr_live, regs[rd_addr_a]);
        rd_data_b = read_port(rd_addr_b, wr_live, regs[rd_addr_b]);
        rd_busy_a = busy[rd_addr_a] && !(wr_live && (wr_addr == rd_addr_a));
        rd_busy_b = busy[rd_addr_b] && !(wr_live && (wr_addr == rd_addr_b));
    end

    // Register storage write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Scoreboard: busy bits, their population count and the sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (clr_ok)
                busy[wr_addr] <= 1'b0;
            if (iss_ok)
                busy[iss_addr] <= 1'b1;
            case ({cnt_inc, cnt_dec})
                2'b10:   busy_cnt <= busy_cnt + CNT_ONE;
                2'b01:   busy_cnt <= busy_cnt - CNT_ONE;
                default: busy_cnt <= busy_cnt;
            endcase
            if (dbl_iss)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed bench for reg_file_sb. Two instances share the
// inputs: z1 has a hardwired-zero register 0, z0 treats register 0 normally.
module tb_reg_file_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;

    logic [DATA_W-1:0] z1_data_a, z1_data_b, z0_data_a, z0_data_b;
    logic              z1_busy_a, z1_busy_b, z0_busy_a, z0_busy_b;
    logic [ADDR_W:0]   z1_cnt, z0_cnt;
    logic              z1_err, z0_err;

    int vectors;
    int miscompares;

    reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) u_z1 (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(z1_data_a), .rd_data_b(z1_data_b),
        .rd_busy_a(z1_busy_a), .rd_busy_b(z1_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy_cnt(z1_cnt), .err(z1_err)
    );

    reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(0)) u_z0 (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(z0_data_a), .rd_data_b(z0_data_b),
        .rd_busy_a(z0_busy_a), .rd_busy_b(z0_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy_cnt(z0_cnt), .err(z0_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        rd_addr_a = 5'd5;
        rd_addr_b = 5'd0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        iss_en    = 1'b0;
        iss_addr  = '0;

        // Reset state
        tick();
        tick();
        chk("rst_data_a", z1_data_a, 0);
        chk("rst_busy_a", z1_busy_a, 0);
        chk("rst_cnt", z1_cnt, 0);
        chk("rst_err", z1_err, 0);
        rst_n = 1'b1;

        // Write r5, bypass in the write cycle, storage afterwards
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        rd_addr_a = 5'd5; rd_addr_b = 5'd5;
        #1;
        chk("bypass_a", z1_data_a, 32'hDEADBEEF);
        chk("bypass_b", z1_data_b, 32'hDEADBEEF);
        tick();
        wr_en = 1'b0; rd_addr_b = 5'd6;
        #1;
        chk("stored_a", z1_data_a, 32'hDEADBEEF);
        chk("other_b", z1_data_b, 0);
        chk("nonbusy_write_cnt", z1_cnt, 0);

        // Register 0: hardwired on z1, ordinary on z0
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
        iss_en = 1'b1; iss_addr = 5'd0; rd_addr_a = 5'd0;
        #1;
        chk("r0_bypass_z1", z1_data_a, 0);
        chk("r0_busy_z1", z1_busy_a, 0);
        chk("r0_bypass_z0", z0_data_a, 32'h12345678);
        tick();
        wr_en = 1'b0; iss_en = 1'b0;
        #1;
        chk("r0_read_z1", z1_data_a, 0);
        chk("r0_cnt_z1", z1_cnt, 0);
        chk("r0_read_z0", z0_data_a, 32'h12345678);
        chk("r0_cnt_z0", z0_cnt, 1);

        // Issue r3, r7; writeback r3 hides busy in the same cycle
        iss_en = 1'b1; iss_addr = 5'd3;
        tick();
        iss_addr = 5'd7;
        tick();
        iss_en = 1'b0; rd_addr_a = 5'd3; rd_addr_b = 5'd7;
        #1;
        chk("iss2_cnt", z1_cnt, 2);
        chk("iss2_busy_a", z1_busy_a, 1);
        chk("iss2_busy_b", z1_busy_b, 1);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33330003;
        #1;
        chk("wb3_busy_a", z1_busy_a, 0);
        chk("wb3_data_a", z1_data_a, 32'h33330003);
        chk("wb3_busy_b", z1_busy_b, 1);
        tick();
        wr_en = 1'b0;
        #1;
        chk("wb3_cnt", z1_cnt, 1);
        chk("wb3_busy_after", z1_busy_a, 0);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
        tick();
        wr_en = 1'b0;
        #1;
        chk("wb7_cnt", z1_cnt, 0);

        // Double issue sets the sticky error
        iss_en = 1'b1; iss_addr = 5'd9;
        tick();
        #1;
        chk("iss9_err_clear", z1_err, 0);
        tick();
        iss_en = 1'b0;
        #1;
        chk("dbl_err", z1_err, 1);
        chk("dbl_cnt", z1_cnt, 1);
        do_reset();
        #1;
        chk("err_cleared_by_rst", z1_err, 0);

        // Issue and write the same register in one cycle: new producer wins
        iss_en = 1'b1; iss_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        tick();
        iss_en = 1'b0; wr_en = 1'b0; rd_addr_a = 5'd9;
        #1;
        chk("same_err", z1_err, 0);
        chk("same_cnt", z1_cnt, 1);
        chk("same_busy", z1_busy_a, 1);
        chk("same_data", z1_data_a, 32'h99);
        iss_en = 1'b1; wr_en = 1'b1; wr_data = 32'h9A;
        tick();
        iss_en = 1'b0; wr_en = 1'b0;
        #1;
        chk("reiss_wb_err", z1_err, 0);
        chk("reiss_wb_cnt", z1_cnt, 1);
        chk("reiss_wb_data", z1_data_a, 32'h9A);

        // Reset mid-operation with pending registers
        iss_en = 1'b1; iss_addr = 5'd4;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hA5A5A5A5;
        tick();
        wr_en = 1'b0; iss_addr = 5'd9;
        tick();
        iss_en = 1'b0; rd_addr_a = 5'd4; rd_addr_b = 5'd9;
        #1;
        chk("pre_rst_err", z1_err, 1);
        chk("pre_rst_cnt", z1_cnt, 2);
        chk("pre_rst_data", z1_data_a, 32'hA5A5A5A5);
        chk("pre_rst_busy", z1_busy_a, 1);
        rst_n = 1'b0;
        #1;
        chk("async_data_a", z1_data_a, 0);
        chk("async_busy_a", z1_busy_a, 0);
        chk("async_busy_b", z1_busy_b, 0);
        chk("async_cnt", z1_cnt, 0);
        chk("async_err", z1_err, 0);
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
        iss_en = 1'b1; iss_addr = 5'd6; rd_addr_b = 5'd6;
        #1;
        chk("rst_no_bypass", z1_data_b, 0);
        tick();
        chk("rst_ignore_iss", z1_cnt, 0);
        wr_en = 1'b0; iss_en = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rst_ignore_wr", z1_data_b, 0);
        chk("rst_ignore_busy", z1_busy_b, 0);

        // Fill the whole scoreboard, then drain it
        for (int i = 0; i < 32; i++) begin
            iss_en = 1'b1; iss_addr = ADDR_W'(i);
            tick();
        end
        iss_en = 1'b0; rd_addr_a = 5'd0;
        #1;
        chk("full_cnt_z0", z0_cnt, 32);
        chk("full_cnt_z1", z1_cnt, 31);
        chk("full_err_z0", z0_err, 0);
        chk("full_busy0_z0", z0_busy_a, 1);
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = DATA_W'(100 + i);
            tick();
        end
        wr_en = 1'b0; rd_addr_a = 5'd0; rd_addr_b = 5'd31;
        #1;
        chk("drain_cnt_z0", z0_cnt, 0);
        chk("drain_cnt_z1", z1_cnt, 0);
        chk("drain_r0_z0", z0_data_a, 100);
        chk("drain_r0_z1", z1_data_a, 0);
        chk("drain_r31_z0", z0_data_b, 131);
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h1F;
        tick();
        wr_en = 1'b0;
        #1;
        chk("no_wrap_z0", z0_cnt, 0);
        chk("no_wrap_data", z0_data_b, 32'h1F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; register count NREGS = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 1; 1 hardwires register 0 to zero, 0 makes register 0 an ordinary register.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rd_addr_a  input  ADDR_W  read port A address.
REQ-007 SHALL have port rd_addr_b  input  ADDR_W  read port B address.
REQ-008 SHALL have port rd_data_a  output  DATA_W  read port A data.
REQ-009 SHALL have port rd_data_b  output  DATA_W  read port B data.
REQ-010 SHALL have port rd_busy_a  output  1  port A register has an outstanding producer.
REQ-011 SHALL have port rd_busy_b  output  1  port B register has an outstanding producer.
REQ-012 SHALL have port wr_en  input  1  writeback strobe.
REQ-013 SHALL have port wr_addr  input  ADDR_W  writeback address.
REQ-014 SHALL have port wr_data  input  DATA_W  writeback data.
REQ-015 SHALL have port iss_en  input  1  issue strobe; marks iss_addr as pending.
REQ-016 SHALL have port iss_addr  input  ADDR_W  destination register of the issued op.
REQ-017 SHALL have port busy_cnt  output  ADDR_W+1  number of busy registers.
REQ-018 SHALL have port err  output  1  sticky double-issue error flag.

Function
REQ-019 SHALL update storage on the rising clk edge when wr_en=1: reg[wr_addr] <= wr_data; writes to register 0 are discarded when ZERO_REG=1.
REQ-020 SHALL produce read data combinationally, zero-latency, from addresses and the current storage.
REQ-021 SHALL bypass write data: when wr_en=1 and wr_addr equals a read address (and is not hardwired zero), that port returns wr_data in the same cycle.
REQ-022 SHALL return 0 on any read of register 0 when ZERO_REG=1, regardless of bypass.
REQ-023 SHALL hold one busy bit per register; iss_en=1 sets busy[iss_addr] at the clock edge.
REQ-024 SHALL clear busy[wr_addr] at the clock edge when wr_en=1 and no issue targets the same address in that cycle.
REQ-025 SHALL, on iss_en and wr_en to the same address in one cycle, write the data and leave busy set (new producer wins).
REQ-026 SHALL leave busy unchanged on a write to a non-busy register; the write still takes effect.
REQ-027 SHALL ignore iss_en targeting register 0 when ZERO_REG=1 (busy[0] constant 0).
REQ-028 SHALL drive rd_busy_x = busy[rd_addr_x] AND NOT (wr_en AND wr_addr==rd_addr_x), i.e. a same-cycle writeback hides busy.
REQ-029 SHALL set err at the clock edge when iss_en targets a register already busy and not being cleared by wr_en that cycle; busy remains set; err stays 1 until reset.
REQ-030 SHALL register busy_cnt as the population count of busy bits, updated in the same edge as busy (+1, -1, or unchanged; never wraps, range 0..NREGS).
REQ-031 SHALL treat read ports A and B independently; identical addresses return identical data and busy.

Reset
REQ-032 SHALL, on rst_n=0, asynchronously clear all storage to 0, all busy bits to 0, busy_cnt to 0 and err to 0.
REQ-033 SHALL ignore wr_en and iss_en while rst_n=0; operation resumes on the first rising edge after rst_n deasserts.
REQ-034 SHALL, on reset asserted mid-operation with pending registers, drop all pending state (rd_busy_a/b=0 immediately).

Verification
REQ-035 Reset then write 0xDEADBEEF to r5, next cycle read A=5 -> rd_data_a=0xDEADBEEF; same-cycle read during write -> 0xDEADBEEF via bypass.
REQ-036 ZERO_REG=1: write 0x12345678 to r0, iss_en to r0 -> rd_data_a(0)=0, rd_busy_a=0, busy_cnt=0.
REQ-037 Issue r3, r7 -> busy_cnt=2, rd_busy_a(3)=1; writeback r3 -> in that cycle rd_busy_a=0, rd_data_a=wr_data; next cycle busy_cnt=1.
REQ-038 Issue r9, then issue r9 again without writeback -> err=1, busy_cnt=1; same-cycle issue+write r9 from clean -> err=0, busy stays 1.
REQ-039 Issue all 32 registers (ZERO_REG=0) -> busy_cnt=32; write all back -> busy_cnt=0, no wrap.
REQ-040 Assert rst_n=0 mid-sequence with r4 busy and 0xA5A5A5A5 stored -> all reads 0, busy_cnt=0, err=0 before next clk edge.
